logo_anim_ctrl: RTL and testbench
=================================

Name: logo_anim_ctrl

Overview:
- Frame-synchronous sequencer for the VGA logo painters.
- Reveals logo letters one at a time, then animates the shared horizontal offset `delt` that every letter painter adds to its rectangle X origins.
- Sits between the VGA sync generator, which supplies `vsync`, and the letter painters, which consume `letter_en` and `delt`.
- All outputs change only just after a vsync falling edge, so no tearing occurs mid-frame.

Parameters:
- N_LETTERS, 4, number of letter painters sequenced; width of `letter_en`.
- REVEAL_FRAMES, 30, frames between successive letter enables during reveal.
- FRAMES_PER_STEP, 1, frames between offset updates during scroll.
- STEP, 2, offset increment per update (pixels); must be ≥1 and ≤ DELT_MAX.
- DELT_MAX, 400, maximum offset value (pixels, fits 11 bits).

Ports:
- `clk`, input, 1, pixel/system clock.
- `rst`, input, 1, reset; asynchronous, active-low.
- `enable`, input, 1, level; high runs the animation, low returns it to idle.
- `pause`, input, 1, level; freezes frame counters, `delt` and `letter_en`.
- `vsync`, input, 1, VGA vertical sync, active-low, asynchronous to the logic (2-flop synchronised).
- `delt`, output, 11, horizontal offset for the letter painters, unsigned.
- `letter_en`, output, N_LETTERS, per-letter enable; bit 0 = leftmost letter.
- `frame_tick`, output, 1, one-cycle pulse per detected vsync falling edge.
- `busy`, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (`rst` low, asynchronous): state IDLE; `delt`=0; `letter_en`=0; `frame_tick`=0; `busy`=0; direction=RIGHT; frame counter=0; sync flops=1.
- vsync path: 2-flop synchroniser, then falling-edge detect. `frame_tick` is asserted the cycle after the second flop goes 1→0; latency is 3 `clk` from the `vsync` edge. It pulses regardless of state or `pause`.
- All state, counter and output updates happen only on `frame_tick` cycles and are registered, visible the cycle after `frame_tick`. The `enable`-low exception is below.
- IDLE:
  - Outputs held at reset values.
  - `enable`=1 at a `frame_tick` → REVEAL with `letter_en`=…0001 and counter=0.
- REVEAL:
  - Counter increments per tick.
  - When counter reaches REVEAL_FRAMES-1: counter←0 and `letter_en`←(`letter_en`<<1)|1.
  - When `letter_en` becomes all ones → SCROLL, counter=0.
  - N_LETTERS=1 goes straight to SCROLL on the entry tick.
- SCROLL:
  - Counter increments per tick. When it reaches FRAMES_PER_STEP-1: counter←0 and `delt` is updated.
  - RIGHT: if `delt`+STEP > DELT_MAX then `delt`←DELT_MAX and dir←LEFT, else `delt`+=STEP.
  - LEFT: if `delt` < STEP then `delt`←0 and dir←RIGHT, else `delt`-=STEP.
  - Sum computed at 12 bits; no 11-bit overflow possible.
- `enable` low in any state:
  - Next `clk` edge: IDLE, `delt`=0, `letter_en`=0, dir=RIGHT, counter=0. This is not tick-gated.
  - Re-enable restarts from the reveal.
- `pause`=1: ticks are ignored for state, counter and outputs. Release resumes the exact counter value.
- `enable` falling on the same cycle as a tick: IDLE wins.
- `busy` = (state≠IDLE), registered.

Optional Feature:
- Macro: LOGO_ANIM_WRAP_EN.
- Defined: SCROLL is a one-way marquee. If `delt`+STEP > DELT_MAX then `delt`←0, else `delt`+=STEP. Direction is unused (held RIGHT).
- Undefined: bounce behaviour as specified above.

Decomposition:
- Shared package `logo_pkg`:
  - State enum (IDLE, REVEAL, SCROLL).
  - Direction enum (RIGHT, LEFT).
  - Default constants: DELT_W=11, DELT_MAX_DEF=400, STEP_DEF=2.
  - The same constants are used by the letter painters.
- One sub-module: `vsync_edge_det` (2-flop synchroniser plus falling-edge pulse). It is reusable for the hsync-based blocks.

Test Plan:
- Async reset mid-SCROLL (`delt`=120, dir LEFT): assert `rst` low → all outputs 0 immediately without a clock; after release and `enable`=1, the first tick gives `letter_en`=0001.
- Reveal timing, defaults, `enable`=1: `letter_en` = 0001, 0011, 0111, 1111 at ticks 1, 31, 61, 91; the state is SCROLL after tick 91; `delt` stays 0 throughout.
- Bounce, STEP=3, DELT_MAX=10: `delt` sequence 3, 6, 9, 10 (dir flips), 7, 4, 1, 0 (dir flips), 3.
- `pause` for 5 ticks in SCROLL at `delt`=40: `delt` stays 40 and `frame_tick` still pulses 5 times; on release the next tick gives 42.
- `enable` drop on a tick cycle at `delt`=200: next cycle `delt`=0, `letter_en`=0, `busy`=0.
- LOGO_ANIM_WRAP_EN defined, STEP=4, DELT_MAX=10: `delt` 4, 8, 0, 4, and no direction reversal.

Source files
------------

// File: rtl/logo_pkg.sv
// logo_pkg: shared states, directions and default geometry for the logo painters
package logo_pkg;
  localparam int DELT_W = 11;
  localparam int DELT_MAX_DEF = 400;
  localparam int STEP_DEF = 2;
  typedef enum logic [1:0] {IDLE, REVEAL, SCROLL} state_e;
  typedef enum logic {RIGHT, LEFT} dir_e;
endpackage

// File: rtl/vsync_edge_det.sv
// vsync_edge_det: 2-flop synchroniser plus registered falling-edge pulse
// Ports: clk, rst_n (async active-low), sig_i (async level), fall_o (1-cycle pulse, 3 clk after sig_i falls)
module vsync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic fall_o
);
  // [0],[1] synchronise; [2] holds the previous synchronised value
  logic [2:0] sync_q;
  logic fall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], sig_i};
      fall_q <= sync_q[2] & ~sync_q[1];
    end
  end
  assign fall_o = fall_q;
endmodule

// File: rtl/logo_anim_ctrl.sv
// logo_anim_ctrl: frame-synchronous letter reveal and horizontal offset animation
// Ports: clk; rst (async active-low); enable, pause (levels); vsync (async, active-low);
//        delt (offset), letter_en (bit 0 = leftmost), frame_tick (vsync fall pulse), busy (not IDLE)
// Build option: LOGO_ANIM_WRAP_EN selects a one-way wrapping marquee instead of bouncing.
module logo_anim_ctrl
  import logo_pkg::*;
#(
  parameter int N_LETTERS       = 4,
  parameter int REVEAL_FRAMES   = 30,
  parameter int FRAMES_PER_STEP = 1,
  parameter int STEP            = STEP_DEF,
  parameter int DELT_MAX        = DELT_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 pause,
  input  logic                 vsync,
  output logic [DELT_W-1:0]    delt,
  output logic [N_LETTERS-1:0] letter_en,
  output logic                 frame_tick,
  output logic                 busy
);
  localparam int CNT_W = 16;
  state_e state_q, state_d;
  dir_e dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DELT_W-1:0] delt_q, delt_d;
  logic [N_LETTERS-1:0] le_q, le_d, le_shift;
  logic [DELT_W:0] sum;
  logic busy_q, tick, over;
  vsync_edge_det u_vsync (
    .clk   (clk),
    .rst_n (rst),
    .sig_i (vsync),
    .fall_o(tick)
  );
  always_comb begin
    sum = {1'b0, delt_q} + (DELT_W+1)'(STEP);
    over = sum > (DELT_W+1)'(DELT_MAX);
    le_shift = (le_q << 1) | N_LETTERS'(1);
    state_d = state_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    delt_d = delt_q;
    le_d = le_q;
    // enable low is checked every clock, not just on ticks, and beats a coincident tick
    if (!enable) begin
      state_d = IDLE;
      dir_d = RIGHT;
      cnt_d = '0;
      delt_d = '0;
      le_d = '0;
    end else if (tick && !pause) begin
      unique case (state_q)
        IDLE: begin
          le_d = N_LETTERS'(1);
          cnt_d = '0;
          state_d = (N_LETTERS == 1) ? SCROLL : REVEAL;
        end
        REVEAL: begin
          if (cnt_q == CNT_W'(REVEAL_FRAMES - 1)) begin
            cnt_d = '0;
            le_d = le_shift;
            state_d = &le_shift ? SCROLL : REVEAL;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
        SCROLL: begin
          if (cnt_q == CNT_W'(FRAMES_PER_STEP - 1)) begin
            cnt_d = '0;
`ifdef LOGO_ANIM_WRAP_EN
            delt_d = over ? '0 : sum[DELT_W-1:0];
`else
            if (dir_q == RIGHT) begin
              delt_d = over ? DELT_W'(DELT_MAX) : sum[DELT_W-1:0];
              dir_d = over ? LEFT : RIGHT;
            end else begin
              delt_d = (delt_q < DELT_W'(STEP)) ? '0 : delt_q - DELT_W'(STEP);
              dir_d = (delt_q < DELT_W'(STEP)) ? RIGHT : LEFT;
            end
`endif
          end else cnt_d = cnt_q + CNT_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dir_q <= RIGHT;
      cnt_q <= '0;
      delt_q <= '0;
      le_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      delt_q <= delt_d;
      le_q <= le_d;
      busy_q <= state_d != IDLE;
    end
  end
  assign delt = delt_q;
  assign letter_en = le_q;
  assign frame_tick = tick;
  assign busy = busy_q;
endmodule

// File: tb/tb_logo_anim_ctrl.sv
// tb_logo_anim_ctrl: scoreboard bench for two logo_anim_ctrl configurations
module tb_logo_anim_ctrl;
  localparam int NA = 4, RFA = 30, FPSA = 1, STA = 2, MXA = 400;
  localparam int NB = 3, RFB = 3, FPSB = 2, STB = 3, MXB = 10;
  typedef struct packed {logic busy; logic [15:0] le; logic [10:0] delt;} obs_t;
  typedef struct packed {obs_t a; obs_t b;} exp_t;
  logic clk = 0, rst = 0, enable = 0, pause = 0, vsync = 1;
  logic [10:0] delt_a, delt_b;
  logic [NA-1:0] le_a;
  logic [NB-1:0] le_b;
  logic tick_a, tick_b, busy_a, busy_b;
  exp_t q[$];
  int checks = 0, passed = 0, ticks_seen = 0, ticks_issued = 0, k = 0;
  always #5 clk = ~clk;
  logo_anim_ctrl dut_a (
    .clk(clk), .rst(rst), .enable(enable), .pause(pause), .vsync(vsync),
    .delt(delt_a), .letter_en(le_a), .frame_tick(tick_a), .busy(busy_a)
  );
  logo_anim_ctrl #(.N_LETTERS(NB), .REVEAL_FRAMES(RFB), .FRAMES_PER_STEP(FPSB), .STEP(STB), .DELT_MAX(MXB)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .pause(pause), .vsync(vsync),
    .delt(delt_b), .letter_en(le_b), .frame_tick(tick_b), .busy(busy_b)
  );
  function automatic int pos(int s, int step, int mx);
    int d = 0;
    bit left = 0;
    repeat (s) begin
`ifdef LOGO_ANIM_WRAP_EN
      d = (d + step > mx) ? 0 : d + step;
`else
      if (!left) begin
        if (d + step > mx) begin d = mx; left = 1; end
        else d = d + step;
      end else begin
        if (d < step) begin d = 0; left = 0; end
        else d = d - step;
      end
`endif
    end
    return d;
  endfunction
  // k = effective ticks since the animation was (re)started; 0 means idle
  function automatic obs_t model(int kk, int n, int rf, int fps, int step, int mx);
    obs_t o;
    int t;
    o = '0;
    if (kk == 0) return o;
    t = 1 + (n - 1) * rf;
    o.busy = 1'b1;
    if (kk < t) o.le = 16'((1 << (1 + (kk - 1) / rf)) - 1);
    else begin
      o.le = 16'((1 << n) - 1);
      o.delt = 11'(pos((kk - t) / fps, step, mx));
    end
    return o;
  endfunction
  function automatic obs_t obs_a();
    return {busy_a, 16'(le_a), delt_a};
  endfunction
  function automatic obs_t obs_b();
    return {busy_b, 16'(le_b), delt_b};
  endfunction
  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got busy=%0b le=%b delt=%0d, expected busy=%0b le=%b delt=%0d",
                  name, act.busy, act.le, act.delt, exp.busy, exp.le, exp.delt);
  endtask
  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask
  initial forever begin
    @(negedge clk);
    if (tick_a === 1'b1) begin
      exp_t e;
      ticks_seen++;
      check_bit("tick_b", tick_b, 1'b1);
      @(negedge clk);
      check_bit("tick_pulse", tick_a, 1'b0);
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_tick: got frame_tick with no pending frame, expected none");
      end else begin
        e = q.pop_front();
        check("frame_a", obs_a(), e.a);
        check("frame_b", obs_b(), e.b);
      end
    end
  end
  task automatic frame(input bit drop);
    exp_t e;
    bit seen = 0;
    if (drop || !enable) k = 0;
    else if (!pause) k++;
    e.a = model(k, NA, RFA, FPSA, STA, MXA);
    e.b = model(k, NB, RFB, FPSB, STB, MXB);
    q.push_back(e);
    ticks_issued++;
    vsync = 0;
    if (drop) begin
      for (int i = 0; i < 8 && !seen; i++) begin
        @(negedge clk);
        if (tick_a === 1'b1) seen = 1;
      end
      if (seen) enable = 0;
      else begin
        checks++;
        $display("FAIL drop_tick: got no frame_tick within 8 cycles, expected one");
      end
    end
    repeat (4) @(posedge clk);
    #2 vsync = 1;
    repeat (6) @(posedge clk);
    #2;
  endtask
  task automatic drop_now();
    enable = 0;
    k = 0;
    @(posedge clk);
    @(negedge clk);
    check("drop_a", obs_a(), '0);
    check("drop_b", obs_b(), '0);
    @(posedge clk);
    #2;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", obs_a(), '0);
    check("reset_b", obs_b(), '0);
    check_bit("reset_tick", tick_a, 1'b0);
    @(posedge clk);
    #2 rst = 1;
    enable = 1;
    repeat (95) frame(0);
    pause = 1;
    repeat (5) frame(0);
    pause = 0;
    repeat (3) frame(0);
    for (int i = 0; i < 320; i++) begin
      pause = ($urandom_range(0, 9) == 0);
      frame(0);
    end
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 99);
      pause = ($urandom_range(0, 7) == 0);
      if (r < 3) begin
        drop_now();
        if ($urandom_range(0, 1) == 1) frame(0);
        enable = 1;
      end else if (r < 5) begin
        frame(1);
        enable = 1;
      end else frame(0);
    end
    pause = 0;
    repeat (40) frame(0);
    frame(1);
    enable = 1;
    repeat (100) frame(0);
    @(posedge clk);
    #3 rst = 0;
    k = 0;
    #1;
    check("async_rst_a", obs_a(), '0);
    check("async_rst_b", obs_b(), '0);
    check_bit("async_rst_tick", tick_a, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1;
    repeat (4) frame(0);
    repeat (5) @(posedge clk);
    checks++;
    if (ticks_seen == ticks_issued && q.size() == 0) passed++;
    else $display("FAIL tick_count: got %0d ticks with %0d pending, expected %0d ticks with 0 pending",
                  ticks_seen, q.size(), ticks_issued);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
